// File: rtl/axis_pkt_fifo.sv
// axis_pkt_fifo: AXI-Stream FIFO with tkeep/tlast sideband, occupancy and packet
// counters, registered almost-full/almost-empty flags, synchronous flush and an
// optional store-and-forward packet mode. Read side is first-word-fall-through.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   flush               synchronous clear of stored contents
//   s_axis_*            ingress stream (tdata/tkeep/tlast/tvalid/tready)
//   m_axis_*            egress stream  (tdata/tkeep/tlast/tvalid/tready)
//   occupancy           stored entries, 0..DEPTH
//   pkt_count           complete packets (tlast beats) stored
//   almost_full         occupancy >= AF_THRESH, registered
//   almost_empty        occupancy <= AE_THRESH, registered
module axis_pkt_fifo #(
  parameter int unsigned DWIDTH    = 64,
  parameter int unsigned DEPTH     = 64,
  parameter int unsigned PKT_MODE  = 0,
  parameter int unsigned AF_THRESH = DEPTH / 2,
  parameter int unsigned AE_THRESH = 2,
  localparam int unsigned N        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DWIDTH-1:0]     s_axis_tdata,
  input  logic [DWIDTH/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DWIDTH-1:0]     m_axis_tdata,
  output logic [DWIDTH/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [N:0]            occupancy,
  output logic [N:0]            pkt_count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned KW  = DWIDTH / 8;
  localparam int unsigned EW  = DWIDTH + KW + 1;
  localparam logic [N:0] DEPTH_LVL = (N+1)'(DEPTH);
  localparam logic [N:0] AF_LVL    = (N+1)'(AF_THRESH);
  localparam logic [N:0] AE_LVL    = (N+1)'(AE_THRESH);
  localparam bit         STORE_FWD = (PKT_MODE != 0);

  logic [EW-1:0] mem_q [DEPTH];

  logic [N:0] wr_ptr_q, wr_ptr_d;
  logic [N:0] rd_ptr_q, rd_ptr_d;
  logic [N:0] pkt_count_q, pkt_count_d;
  logic       almost_full_q, almost_full_d;
  logic       almost_empty_q, almost_empty_d;

  logic [N:0] occ;
  logic       is_full, is_empty;
  logic       push, pop, push_last, pop_last;

  // Status derived only from registered pointers.
  assign occ      = wr_ptr_q - rd_ptr_q;
  assign is_full  = (occ == DEPTH_LVL);
  assign is_empty = (occ == '0);

  assign s_axis_tready = ~is_full & ~flush;
  // Store-and-forward waits for a complete packet; a full FIFO cuts through so
  // packets longer than DEPTH still drain.
  assign m_axis_tvalid = ~is_empty & (~STORE_FWD | (pkt_count_q != '0) | is_full);

  assign {m_axis_tlast, m_axis_tkeep, m_axis_tdata} = mem_q[rd_ptr_q[N-1:0]];

  assign push      = s_axis_tvalid & s_axis_tready;
  assign pop       = m_axis_tvalid & m_axis_tready;
  assign push_last = push & s_axis_tlast;
  assign pop_last  = pop & m_axis_tlast;

  assign occupancy    = occ;
  assign pkt_count    = pkt_count_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;

  // Next-state for pointers, packet counter and flags.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    pkt_count_d    = pkt_count_q;
    almost_full_d  = (occ >= AF_LVL);
    almost_empty_d = (occ <= AE_LVL);

    if (push) wr_ptr_d = wr_ptr_q + (N+1)'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + (N+1)'(1);

    // Saturate at zero: a cut-through pop of tlast must not wrap the count.
    if (push_last && !pop_last) begin
      pkt_count_d = pkt_count_q + (N+1)'(1);
    end else if (!push_last && pop_last && (pkt_count_q != '0)) begin
      pkt_count_d = pkt_count_q - (N+1)'(1);
    end

    // Push is already blocked by tready, so only the read side moves.
    if (flush) begin
      rd_ptr_d    = wr_ptr_q;
      pkt_count_d = '0;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      pkt_count_q    <= '0;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      pkt_count_q    <= pkt_count_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  // Storage array; contents are not reset.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[N-1:0]] <= {s_axis_tlast, s_axis_tkeep, s_axis_tdata};
  end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Bench for axis_pkt_fifo: one cut-through and one store-and-forward instance,
// each fed from its own source queue and compared every cycle against a
// queue-based reference model.
module tb_axis_pkt_fifo;

  localparam int DEPTH = 64;
  localparam int AF    = 32;
  localparam int AE    = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        m_tready;

  logic [63:0] s_tdata  [2];
  logic [7:0]  s_tkeep  [2];
  logic        s_tlast  [2];
  logic        s_tvalid [2];
  logic        s_tready [2];
  logic [63:0] m_tdata  [2];
  logic [7:0]  m_tkeep  [2];
  logic        m_tlast  [2];
  logic        m_tvalid [2];
  logic [6:0]  occupancy [2];
  logic [6:0]  pkt_cnt   [2];
  logic        almost_full  [2];
  logic        almost_empty [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    axis_pkt_fifo #(.DWIDTH(64), .DEPTH(DEPTH), .PKT_MODE(g)) u_dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .s_axis_tdata  (s_tdata[g]),
      .s_axis_tkeep  (s_tkeep[g]),
      .s_axis_tlast  (s_tlast[g]),
      .s_axis_tvalid (s_tvalid[g]),
      .s_axis_tready (s_tready[g]),
      .m_axis_tdata  (m_tdata[g]),
      .m_axis_tkeep  (m_tkeep[g]),
      .m_axis_tlast  (m_tlast[g]),
      .m_axis_tvalid (m_tvalid[g]),
      .m_axis_tready (m_tready),
      .occupancy     (occupancy[g]),
      .pkt_count     (pkt_cnt[g]),
      .almost_full   (almost_full[g]),
      .almost_empty  (almost_empty[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int bubble = 0;
  int obs_pops [2];

  // Reference state: beats waiting at each source, beats held in each FIFO,
  // and the expected registered flags.
  logic [72:0] srcq [2][$];
  logic [72:0] mq   [2][$];
  bit          af_e [2];
  bit          ae_e [2];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [72:0] rbeat(input bit last);
    return {last, 8'($urandom), 32'($urandom), 32'($urandom)};
  endfunction

  function automatic int tlast_cnt(input int d);
    int c = 0;
    foreach (mq[d][i]) if (mq[d][i][72]) c++;
    return c;
  endfunction

  task automatic add_beat(input logic [72:0] b);
    srcq[0].push_back(b);
    srcq[1].push_back(b);
  endtask

  // One clock: drive sources, compare at the falling edge, advance the model.
  task automatic cycle(input bit chk_on);
    bit pu [2];
    bit po [2];
    int occ_e, pk_e;
    bit rdy_e, vld_e;
    for (int d = 0; d < 2; d++) begin
      if (srcq[d].size() != 0 && (bubble == 0 || $urandom_range(0, 99) >= bubble)) begin
        s_tvalid[d] = 1'b1;
        {s_tlast[d], s_tkeep[d], s_tdata[d]} = srcq[d][0];
      end else begin
        s_tvalid[d] = 1'b0;
        {s_tlast[d], s_tkeep[d], s_tdata[d]} = rbeat(1'($urandom));
      end
    end
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      occ_e = mq[d].size();
      pk_e  = tlast_cnt(d);
      rdy_e = (occ_e != DEPTH) && !flush;
      vld_e = (occ_e != 0) && (d == 0 || pk_e != 0 || occ_e == DEPTH);
      if (chk_on) begin
        chk($sformatf("occupancy[%0d]", d), 128'(occupancy[d]), 128'(occ_e));
        chk($sformatf("pkt_count[%0d]", d), 128'(pkt_cnt[d]), 128'(pk_e));
        chk($sformatf("s_tready[%0d]", d), 128'(s_tready[d]), 128'(rdy_e));
        chk($sformatf("m_tvalid[%0d]", d), 128'(m_tvalid[d]), 128'(vld_e));
        chk($sformatf("almost_full[%0d]", d), 128'(almost_full[d]), 128'(af_e[d]));
        chk($sformatf("almost_empty[%0d]", d), 128'(almost_empty[d]), 128'(ae_e[d]));
        if (vld_e)
          chk($sformatf("m_beat[%0d]", d), 128'({m_tlast[d], m_tkeep[d], m_tdata[d]}),
              128'(mq[d][0]));
        if (m_tvalid[d] === 1'b1 && m_tready) obs_pops[d]++;
      end
      pu[d] = s_tvalid[d] && rdy_e;
      po[d] = vld_e && m_tready;
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        mq[d].delete();
        srcq[d].delete();
        af_e[d] = 1'b0;
        ae_e[d] = 1'b1;
      end else begin
        af_e[d] = (mq[d].size() >= AF);
        ae_e[d] = (mq[d].size() <= AE);
        if (flush) begin
          mq[d].delete();
        end else begin
          if (po[d]) void'(mq[d].pop_front());
          if (pu[d]) begin
            mq[d].push_back(srcq[d][0]);
            void'(srcq[d].pop_front());
          end
        end
      end
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1);
  endtask

  // Empty both sources and FIFOs with the sink always ready, within a budget.
  task automatic drain(input bit add_last);
    int n = 0;
    if (add_last) add_beat(rbeat(1'b1));
    m_tready = 1'b1;
    bubble   = 0;
    while ((srcq[0].size() + srcq[1].size() + mq[0].size() + mq[1].size()) != 0 && n < 600) begin
      cycle(1'b1);
      n++;
    end
    chk("drain_done", 128'(n < 600), 128'(1));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle(1'b1);
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    flush    = 1'b0;
    m_tready = 1'b0;
    obs_pops[0] = 0;
    obs_pops[1] = 0;
    for (int d = 0; d < 2; d++) begin
      s_tvalid[d] = 1'b0;
      s_tdata[d]  = '0;
      s_tkeep[d]  = '0;
      s_tlast[d]  = 1'b0;
    end

    // Reset, then check the post-reset state.
    cycle(1'b0);
    cycle(1'b0);
    rst = 1'b0;
    run(2);

    // Single beat through an empty FIFO.
    m_tready = 1'b1;
    add_beat({1'b1, 8'hFF, 64'hA5});
    run(4);

    // Fill to full with the sink stalled; the 65th beat waits at the source.
    m_tready = 1'b0;
    for (int i = 0; i < 65; i++) add_beat(rbeat($urandom_range(0, 7) == 0));
    run(70);

    // Full FIFO with both sides active.
    m_tready = 1'b1;
    for (int i = 0; i < 40; i++) add_beat(rbeat($urandom_range(0, 7) == 0));
    run(40);
    drain(1'b1);

    // Five-beat packet: store-and-forward holds it until tlast is stored.
    do_reset();
    m_tready = 1'b1;
    for (int i = 0; i < 5; i++) add_beat(rbeat(i == 4));
    drain(1'b0);

    // 80-beat packet exceeds DEPTH: store-and-forward cuts through once full.
    do_reset();
    obs_pops[0] = 0;
    obs_pops[1] = 0;
    for (int i = 0; i < 80; i++) add_beat(rbeat(i == 79));
    drain(1'b0);
    chk("pkt80_pops[0]", 128'(obs_pops[0]), 128'(80));
    chk("pkt80_pops[1]", 128'(obs_pops[1]), 128'(80));

    // Flush after ten beats, then reset mid-stream.
    m_tready = 1'b0;
    for (int i = 0; i < 10; i++) add_beat(rbeat($urandom_range(0, 3) == 0));
    run(10);
    flush = 1'b1;
    run(1);
    flush = 1'b0;
    run(3);
    for (int i = 0; i < 10; i++) add_beat(rbeat($urandom_range(0, 3) == 0));
    run(6);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(3);

    // Random traffic: sink stalls, source bubbles, occasional flush.
    bubble = 25;
    for (int i = 0; i < 400; i++) begin
      while (srcq[0].size() < 4) add_beat(rbeat($urandom_range(0, 5) == 0));
      m_tready = ($urandom_range(0, 99) < 60);
      flush    = ($urandom_range(0, 99) < 2);
      cycle(1'b1);
    end
    flush = 1'b0;
    drain(1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
